dino_sprite_fetch: RTL and testbench
====================================

// Module: dino_sprite_fetch
// PURPOSE
//  Read-side client of the 32x32 RGB565 dino sprite ROM (1024 words, addr -> data one clk later).
//  During each horizontal blank it prefetches the sprite row for the upcoming scanline into a line buffer.
//  During active video it emits that row's pixels at the sprite's screen X.
//  Sits between the VGA timing counters and the pixel mux feeding the DE1-SoC VGA output.
// PARAMETERS
//  SPRITE_W         32        sprite width, pixels (power of 2)
//  SPRITE_H         32        sprite height, rows
//  ADDR_W           10        ROM address width = log2(SPRITE_W*SPRITE_H)
//  COLOR_W          16        pixel width, RGB565
//  TRANSPARENT_KEY  16'hF81F  colour treated as transparent (magenta)
// PORTS
//  clk          in   1        system clock; all logic on posedge
//  reset        in   1        synchronous, active-high reset
//  line_start   in   1        1-clk pulse at start of hblank preceding line next_vcount
//  next_vcount  in   10       scanline about to be displayed
//  sprite_x     in   10       sprite left edge, screen pixels; sampled on line_start
//  sprite_y     in   10       sprite top edge, screen lines; sampled on line_start
//  hcount       in   10       current active-video pixel column
//  rom_addr     out  ADDR_W   ROM address, registered
//  rom_data     in   COLOR_W  ROM data; valid 1 clk after rom_addr
//  pix_rgb      out  COLOR_W  sprite pixel for hcount, registered
//  pix_valid    out  1        1 = pix_rgb opaque and inside sprite
//  busy         out  1        1 while a row prefetch is in flight
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0, pix_rgb=0, pix_valid=0, busy=0; row_ok=0. Buffer contents: don't-care.
//  Hit test on line_start uses 11-bit math, so there is no wrap:
//    hit = (next_vcount >= sprite_y) && (next_vcount < sprite_y + SPRITE_H).
//  FSM states: IDLE, FETCH, LAST, READY. line_start has priority in every state, including mid-FETCH (abort + restart).
//    - line_start & hit: latch row = next_vcount - sprite_y and x_lat = sprite_x; set col=0, row_ok=0; go to FETCH.
//    - line_start & !hit: row_ok=0; go to IDLE.
//    - FETCH: each clk, rom_addr <= row*SPRITE_W + col, col++.
//        The datum returned the following clk is written to buf[col-1].
//        After col = SPRITE_W-1 is issued, go to LAST.
//    - LAST: capture the final datum into buf[SPRITE_W-1]; row_ok=1; go to READY.
//    - READY: hold until the next line_start.
//  Timing: first rom_addr is valid 1 clk after line_start. READY is reached SPRITE_W+2 clks after line_start (34 at default).
//  busy = 1 in FETCH and LAST only.
//  Display path (1-clk latency from hcount):
//    - in_spr = row_ok && (hcount >= x_lat) && (hcount < x_lat + SPRITE_W), computed in 11 bits.
//    - Next clk: pix_rgb <= in_spr ? buf[hcount-x_lat] : 0
//                pix_valid <= in_spr && (buf[hcount-x_lat] != TRANSPARENT_KEY).
//  Boundaries:
//    - Sprite clipped at screen right: columns beyond 639 are simply never addressed by hcount.
//    - hcount queried while busy: pix_valid=0.
//    - reset asserted mid-FETCH: back to the reset state the next clk; no further ROM addresses are issued.
// CONFIGURATION
//  SPRITE_MIRROR_EN defined:
//    - Adds input flip_h (1 bit), sampled on line_start.
//    - When flip_h=1, FETCH issues col' = SPRITE_W-1-col but still writes buf[col], so the row is displayed mirrored.
//    - Latency, busy and FSM are unchanged.
//  SPRITE_MIRROR_EN undefined: no flip_h port; addresses are always row*SPRITE_W+col.
// STRUCTURE
//  Package dino_gfx_pkg:
//    - SPRITE_W, SPRITE_H, TRANSPARENT_KEY localparams
//    - typedef logic [15:0] rgb565_t
//    - typedef enum {IDLE, FETCH, LAST, READY} fetch_state_t
//  Sub-module dino_line_buffer: SPRITE_W x COLOR_W register file; 1 sync write port (fetch side), 1 async read port (display side).
//  Top holds the FSM, address generator, 1-clk write-index delay and display compare.
// TESTING
//  - Behavioural ROM model: 1-clk latency, word = {6'(row), 5'(col), 5'b0}.
//  - Directed scenarios:
//    1. Reset -> all outputs 0. sprite_y=100, next_vcount=105, line_start -> rom_addr 160..191 on clks 1..32; busy 1 for 33 clks; READY at clk 34.
//    2. After 1, sprite_x=200, sweep hcount 0..639 -> pix_valid=1 exactly for hcount 200..231, 1 clk late; pix_rgb = row-5 word per column.
//    3. next_vcount=99 and next_vcount=132 with sprite_y=100 -> no ROM accesses, busy=0, pix_valid=0 across the whole line.
//    4. ROM word at col 7 = 16'hF81F -> pix_valid=0 at hcount=x+7 only; neighbours stay valid.
//    5. Second line_start at clk 10 of FETCH -> addresses restart at the new row base; final buffer holds only new-row data.
//    6. reset pulsed mid-FETCH -> busy=0 next clk, rom_addr=0, no buffer writes.
//       With SPRITE_MIRROR_EN, flip_h=1, row 0 -> rom_addr 31..0.

Source files
------------

// File: rtl/dino_gfx_pkg.sv
// Shared constants and types for the dino sprite read path.
package dino_gfx_pkg;

  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 32;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned COLOR_W  = 16;
  localparam int unsigned COL_W    = $clog2(SPRITE_W);
  localparam int unsigned ROW_W    = $clog2(SPRITE_H);

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t TRANSPARENT_KEY = 16'hF81F;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, READY} fetch_state_t;

endpackage

// File: rtl/dino_line_buffer.sv
// One sprite row of pixels: synchronous write from the fetch side,
// asynchronous read for the display compare.
module dino_line_buffer
  import dino_gfx_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [COL_W-1:0]   i_waddr,
  input  logic [COLOR_W-1:0] i_wdata,
  input  logic [COL_W-1:0]   i_raddr,
  output logic [COLOR_W-1:0] o_rdata
);

  logic [COLOR_W-1:0] r_mem [SPRITE_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dino_sprite_fetch.sv
// Prefetches one dino sprite row per hblank from the sprite ROM and emits it during active video.
// Optional SPRITE_MIRROR_EN adds a flip_h input that mirrors the fetched row horizontally.
module dino_sprite_fetch
  import dino_gfx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        next_vcount,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
`ifdef SPRITE_MIRROR_EN
  input  logic              flip_h,
`endif
  input  logic [9:0]        hcount,
  output logic [ADDR_W-1:0] rom_addr,
  input  rgb565_t           rom_data,
  output rgb565_t           pix_rgb,
  output logic              pix_valid,
  output logic              busy
);

  fetch_state_t r_state, w_state_next;

  logic [ROW_W-1:0]  r_row;
  logic [9:0]        r_x_lat;
  logic [COL_W-1:0]  r_col;
  logic              r_row_ok;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_iss_vld;
  logic [COL_W-1:0]  r_iss_col;
  logic              r_wr_vld;
  logic [COL_W-1:0]  r_wr_idx;
  rgb565_t           r_pix_rgb;
  logic              r_pix_valid;

  logic              w_hit;
  logic              w_issue;
  logic              w_last_wr;
  logic [COL_W-1:0]  w_col_eff;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_in_spr;
  logic [COL_W-1:0]  w_rd_idx;
  rgb565_t           w_rd_data;

  assign w_hit = ({1'b0, next_vcount} >= {1'b0, sprite_y}) &&
                 ({1'b0, next_vcount} <  {1'b0, sprite_y} + 11'(SPRITE_H));

`ifdef SPRITE_MIRROR_EN
  logic r_flip;
  // SPRITE_W is a power of two, so SPRITE_W-1-col is the bitwise inverse of col.
  assign w_col_eff = r_flip ? ~r_col : r_col;
`else
  assign w_col_eff = r_col;
`endif

  assign w_issue_addr = {r_row, w_col_eff};
  assign w_last_wr    = r_wr_vld && (r_wr_idx == COL_W'(SPRITE_W - 1));

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      FETCH: begin
        w_issue = 1'b1;
        if (r_col == COL_W'(SPRITE_W - 1)) begin
          w_state_next = LAST;
        end
      end
      LAST: begin
        if (w_last_wr) begin
          w_state_next = READY;
        end
      end
      default: ;
    endcase
    if (line_start) begin
      w_issue      = 1'b0;
      w_state_next = w_hit ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_x_lat     <= '0;
      r_col       <= '0;
      r_row_ok    <= 1'b0;
      r_rom_addr  <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_col   <= '0;
      r_wr_vld    <= 1'b0;
      r_wr_idx    <= '0;
      r_pix_rgb   <= '0;
      r_pix_valid <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      r_flip      <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_iss_vld <= w_issue;
      // Writes still in flight when a new line starts are dropped.
      r_wr_vld  <= r_iss_vld && !line_start;
      r_iss_col <= r_col;
      r_wr_idx  <= r_iss_col;
      if (w_issue) begin
        r_rom_addr <= w_issue_addr;
        r_col      <= r_col + 1'b1;
      end
      if (line_start) begin
        r_row_ok <= 1'b0;
        if (w_hit) begin
          r_row   <= ROW_W'(next_vcount - sprite_y);
          r_x_lat <= sprite_x;
          r_col   <= '0;
`ifdef SPRITE_MIRROR_EN
          r_flip  <= flip_h;
`endif
        end
      end else if ((r_state == LAST) && w_last_wr) begin
        r_row_ok <= 1'b1;
      end
      r_pix_rgb   <= w_in_spr ? w_rd_data : '0;
      r_pix_valid <= w_in_spr && (w_rd_data != TRANSPARENT_KEY);
    end
  end

  assign w_in_spr = r_row_ok &&
                    ({1'b0, hcount} >= {1'b0, r_x_lat}) &&
                    ({1'b0, hcount} <  {1'b0, r_x_lat} + 11'(SPRITE_W));
  assign w_rd_idx = COL_W'(hcount - r_x_lat);

  dino_line_buffer u_line_buffer (
    .i_clk   (clk),
    .i_we    (r_wr_vld),
    .i_waddr (r_wr_idx),
    .i_wdata (rom_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  assign rom_addr  = r_rom_addr;
  assign pix_rgb   = r_pix_rgb;
  assign pix_valid = r_pix_valid;
  assign busy      = r_iss_vld || r_wr_vld;

endmodule

// File: tb/tb_dino_sprite_fetch.sv
// Directed bench for dino_sprite_fetch with a 1-clk sprite ROM model.
module tb_dino_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  next_vcount;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [9:0]  hcount;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] pix_rgb;
  logic        pix_valid;
  logic        busy;
`ifdef SPRITE_MIRROR_EN
  logic        flip_h;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic key_col7 = 1'b0;

  always #5 clk = ~clk;

  // ROM word = {6'(row), 5'(col), 5'b0}; optionally column 7 is the transparent key.
  always @(posedge clk) begin
    if (key_col7 && (rom_addr[4:0] == 5'd7)) rom_data <= 16'hF81F;
    else rom_data <= {1'b0, rom_addr[9:5], rom_addr[4:0], 5'b0};
  end

  dino_sprite_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .next_vcount (next_vcount),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
`ifdef SPRITE_MIRROR_EN
    .flip_h      (flip_h),
`endif
    .hcount      (hcount),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_rgb     (pix_rgb),
    .pix_valid   (pix_valid),
    .busy        (busy)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in clk 0, i.e. just after the edge that sampled line_start.
  task automatic pulse_line(input logic [9:0] vc);
    next_vcount = vc;
    line_start  = 1'b1;
    step(1);
    line_start  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    n_checks++;
    if ({rom_addr, pix_rgb, pix_valid, busy} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d rgb=%h valid=%b busy=%b, want all zero",
               rom_addr, pix_rgb, pix_valid, busy);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_fetch_row;
    int busy_cnt = 0;
    sprite_x = 10'd200;
    sprite_y = 10'd100;
    pulse_line(10'd105);
    for (int k = 1; k <= 34; k++) begin
      step(1);
      if (busy) busy_cnt++;
      if (k <= 32) begin
        n_checks++;
        if (rom_addr !== 10'(160 + k - 1)) begin
          n_fail++;
          $display("FAIL fetch_addr clk %0d: got %0d, want %0d", k, rom_addr, 160 + k - 1);
        end
      end
      if (k == 33 || k == 34) begin
        n_checks++;
        if (busy !== (k == 33)) begin
          n_fail++;
          $display("FAIL fetch_busy clk %0d: got %b, want %b", k, busy, (k == 33));
        end
      end
    end
    n_checks++;
    if (busy_cnt != 33) begin
      n_fail++;
      $display("FAIL fetch_busy_len: got %0d clks, want 33", busy_cnt);
    end
  endtask

  task automatic test_display_sweep;
    logic [15:0] exp_rgb;
    logic        exp_vld;
    logic [4:0]  c;
    for (int h = 0; h < 640; h++) begin
      hcount = 10'(h);
      step(1);
      exp_vld = (h >= 200) && (h <= 231);
      c = 5'(h - 200);
      exp_rgb = exp_vld ? {6'd5, c, 5'b0} : 16'h0000;
      n_checks++;
      if (pix_valid !== exp_vld || pix_rgb !== exp_rgb) begin
        n_fail++;
        $display("FAIL sweep h=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h",
                 h, pix_valid, pix_rgb, exp_vld, exp_rgb);
      end
    end
  endtask

  task automatic test_miss_rows;
    logic [9:0] vcs [2];
    vcs[0] = 10'd99;
    vcs[1] = 10'd132;
    for (int t = 0; t < 2; t++) begin
      pulse_line(vcs[t]);
      for (int k = 0; k < 40; k++) begin
        n_checks++;
        if (busy !== 1'b0 || rom_addr !== 10'd191) begin
          n_fail++;
          $display("FAIL miss_idle vc=%0d clk %0d: got busy=%b addr=%0d, want busy=0 addr=191",
                   vcs[t], k, busy, rom_addr);
        end
        step(1);
      end
      for (int h = 0; h < 640; h++) begin
        hcount = 10'(h);
        step(1);
        n_checks++;
        if (pix_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL miss_pix vc=%0d h=%0d: got valid=%b, want 0", vcs[t], h, pix_valid);
        end
      end
    end
  endtask

  task automatic test_transparent;
    logic [15:0] exp_rgb;
    logic        exp_vld;
    logic        in_spr;
    logic [4:0]  c;
    key_col7 = 1'b1;
    pulse_line(10'd110);
    step(36);
    for (int h = 195; h <= 240; h++) begin
      hcount = 10'(h);
      step(1);
      in_spr  = (h >= 200) && (h <= 231);
      c       = 5'(h - 200);
      exp_vld = in_spr && (h != 207);
      exp_rgb = !in_spr ? 16'h0000 : (h == 207) ? 16'hF81F : {6'd10, c, 5'b0};
      n_checks++;
      if (pix_valid !== exp_vld || pix_rgb !== exp_rgb) begin
        n_fail++;
        $display("FAIL transparent h=%0d: got valid=%b rgb=%h, want valid=%b rgb=%h",
                 h, pix_valid, pix_rgb, exp_vld, exp_rgb);
      end
    end
    key_col7 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_rgb;
    logic [4:0]  c;
    pulse_line(10'd103);
    step(10);
    pulse_line(10'd120);
    for (int k = 1; k <= 32; k++) begin
      step(1);
      n_checks++;
      if (rom_addr !== 10'(640 + k - 1)) begin
        n_fail++;
        $display("FAIL restart_addr clk %0d: got %0d, want %0d", k, rom_addr, 640 + k - 1);
      end
    end
    step(4);
    for (int h = 200; h <= 231; h++) begin
      hcount = 10'(h);
      step(1);
      c = 5'(h - 200);
      exp_rgb = {6'd20, c, 5'b0};
      n_checks++;
      if (pix_valid !== 1'b1 || pix_rgb !== exp_rgb) begin
        n_fail++;
        $display("FAIL restart_pix h=%0d: got valid=%b rgb=%h, want valid=1 rgb=%h",
                 h, pix_valid, pix_rgb, exp_rgb);
      end
    end
  endtask

  task automatic test_reset_mid_fetch;
    pulse_line(10'd107);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (busy !== 1'b0 || rom_addr !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_mid clk %0d: got busy=%b addr=%0d, want busy=0 addr=0",
                 k, busy, rom_addr);
      end
      step(1);
    end
    for (int h = 195; h <= 240; h++) begin
      hcount = 10'(h);
      step(1);
      n_checks++;
      if (pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_pix h=%0d: got valid=%b, want 0", h, pix_valid);
      end
    end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror;
    flip_h = 1'b1;
    pulse_line(10'd100);
    flip_h = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      n_checks++;
      if (rom_addr !== 10'(32 - k)) begin
        n_fail++;
        $display("FAIL mirror_addr clk %0d: got %0d, want %0d", k, rom_addr, 32 - k);
      end
    end
    step(4);
  endtask
`endif

  initial begin
    reset       = 1'b1;
    line_start  = 1'b0;
    next_vcount = '0;
    sprite_x    = '0;
    sprite_y    = '0;
    hcount      = '0;
`ifdef SPRITE_MIRROR_EN
    flip_h      = 1'b0;
`endif
    step(1);
    test_reset;
    test_fetch_row;
    test_display_sweep;
    test_miss_rows;
    test_transparent;
    test_back_to_back;
    test_reset_mid_fetch;
`ifdef SPRITE_MIRROR_EN
    test_mirror;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
